// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch stage: PC, single-outstanding instruction bus reads,
// one-entry skid buffer and the registered decode-stage inputs.
module eco32f_fetch #(
    parameter logic [31:0] RESET_PC = 32'hE0000000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ibus_adr_o,
    output logic        ibus_req_o,
    input  logic        ibus_ack_i,
    input  logic        ibus_err_i,
    input  logic [31:0] ibus_dat_i,
    input  logic        id_stall,
    input  logic        id_flush,
    input  logic        if_redirect,
    input  logic [31:0] if_redirect_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_insn,
    output logic        id_exc_ibus_fault,
    output logic        if_bubble
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_STALLED,
        S_ABORT,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_insn_q, buf_insn_d;
    logic        buf_flt_q, buf_flt_d;
    logic        buf_vld_q, buf_vld_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_insn_q, id_insn_d;
    logic        flt_q, flt_d;
    logic        bub_q, bub_d;

    logic        adv;
    logic        done;
    logic [31:0] redir_pc;

    assign adv      = !id_stall | id_flush;
    assign done     = ibus_ack_i | ibus_err_i;
    assign redir_pc = {if_redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        buf_pc_d   = buf_pc_q;
        buf_insn_d = buf_insn_q;
        buf_flt_d  = buf_flt_q;
        buf_vld_d  = buf_vld_q;
        id_pc_d    = id_pc_q;
        id_insn_d  = id_insn_q;
        flt_d      = flt_q;
        bub_d      = bub_q;

        // Any output load starts as a bubble; real data overrides it below.
        if (if_redirect || adv) begin
            id_pc_d   = pc_q;
            id_insn_d = 32'h0000_0000;
            flt_d     = 1'b0;
            bub_d     = 1'b1;
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (if_redirect) begin
                    if (done) begin
                        pc_d = redir_pc;
                    end else begin
                        tgt_d   = redir_pc;
                        state_d = S_ABORT;
                    end
                end else if (ibus_ack_i) begin
                    pc_d = pc_q + 32'd4;
                    if (adv) begin
                        id_insn_d = ibus_dat_i;
                        bub_d     = 1'b0;
                    end else begin
                        buf_pc_d   = pc_q;
                        buf_insn_d = ibus_dat_i;
                        buf_flt_d  = 1'b0;
                        buf_vld_d  = 1'b1;
                        state_d    = S_STALLED;
                    end
                end else if (ibus_err_i) begin
                    if (adv) begin
                        flt_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        buf_pc_d   = pc_q;
                        buf_insn_d = 32'h0000_0000;
                        buf_flt_d  = 1'b1;
                        buf_vld_d  = 1'b1;
                        state_d    = S_STALLED;
                    end
                end
            end
            S_STALLED: begin
                if (!if_redirect && adv) begin
                    if (buf_vld_q) begin
                        id_pc_d   = buf_pc_q;
                        id_insn_d = buf_insn_q;
                        flt_d     = buf_flt_q;
                        bub_d     = buf_flt_q;
                    end
                    buf_vld_d = 1'b0;
                    state_d   = (buf_vld_q && buf_flt_q) ? S_HALT : S_FETCH;
                end
            end
            S_ABORT: begin
                // The pending response is dropped; a redirect in the same cycle wins.
                if (done) begin
                    pc_d    = if_redirect ? redir_pc : tgt_q;
                    state_d = S_FETCH;
                end else if (if_redirect) begin
                    tgt_d = redir_pc;
                end
            end
            default: begin
            end
        endcase

        if (if_redirect) begin
            buf_vld_d = 1'b0;
            if (state_q != S_FETCH && state_q != S_ABORT) begin
                pc_d    = redir_pc;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            buf_pc_q   <= 32'h0000_0000;
            buf_insn_q <= 32'h0000_0000;
            buf_flt_q  <= 1'b0;
            buf_vld_q  <= 1'b0;
            id_pc_q    <= RESET_PC;
            id_insn_q  <= 32'h0000_0000;
            flt_q      <= 1'b0;
            bub_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            buf_pc_q   <= buf_pc_d;
            buf_insn_q <= buf_insn_d;
            buf_flt_q  <= buf_flt_d;
            buf_vld_q  <= buf_vld_d;
            id_pc_q    <= id_pc_d;
            id_insn_q  <= id_insn_d;
            flt_q      <= flt_d;
            bub_q      <= bub_d;
        end
    end

    assign ibus_req_o        = (state_q == S_FETCH) || (state_q == S_ABORT);
    assign ibus_adr_o        = pc_q;
    assign id_pc             = id_pc_q;
    assign id_insn           = id_insn_q;
    assign id_exc_ibus_fault = flt_q;
    assign if_bubble         = bub_q;

endmodule

// File: tb/tb_eco32f_fetch.sv
// Bench for eco32f_fetch: directed walk through the fetch scenarios, then
// randomized bus/stall/redirect traffic against a transaction-level model.
module tb_eco32f_fetch;

    localparam logic [31:0] RPC = 32'hE0000000;

    logic        clk;
    logic        rst;
    logic [31:0] ibus_adr_o;
    logic        ibus_req_o;
    logic        ibus_ack_i;
    logic        ibus_err_i;
    logic [31:0] ibus_dat_i;
    logic        id_stall;
    logic        id_flush;
    logic        if_redirect;
    logic [31:0] if_redirect_pc;
    logic [31:0] id_pc;
    logic [31:0] id_insn;
    logic        id_exc_ibus_fault;
    logic        if_bubble;

    eco32f_fetch #(.RESET_PC(RPC)) dut (
        .clk               (clk),
        .rst               (rst),
        .ibus_adr_o        (ibus_adr_o),
        .ibus_req_o        (ibus_req_o),
        .ibus_ack_i        (ibus_ack_i),
        .ibus_err_i        (ibus_err_i),
        .ibus_dat_i        (ibus_dat_i),
        .id_stall          (id_stall),
        .id_flush          (id_flush),
        .if_redirect       (if_redirect),
        .if_redirect_pc    (if_redirect_pc),
        .id_pc             (id_pc),
        .id_insn           (id_insn),
        .id_exc_ibus_fault (id_exc_ibus_fault),
        .if_bubble         (if_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a decode slot, a skid queue, and the bus transaction in flight.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        flt;
        logic        bub;
    } ent_t;

    ent_t        m_out;
    ent_t        skid[$];
    logic [31:0] m_pc;
    logic [31:0] m_dest;
    bit          m_boot;
    bit          m_busy;
    bit          m_discard;

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] insn,
                                input logic flt, input logic bub);
        ent_t e;
        e.pc = pc; e.insn = insn; e.flt = flt; e.bub = bub;
        return e;
    endfunction

    task automatic model_reset();
        m_out     = mk(RPC, 32'h0, 1'b0, 1'b1);
        skid.delete();
        m_pc      = RPC;
        m_dest    = RPC;
        m_boot    = 1;
        m_busy    = 0;
        m_discard = 0;
    endtask

    task automatic model_step(input logic st, input logic fl, input logic rd,
                              input logic [31:0] rpc, input logic ak,
                              input logic er, input logic [31:0] dat);
        bit   adv;
        bit   resp;
        ent_t e;
        adv  = !st || fl;
        resp = m_busy && (ak || er);
        if (rd) begin
            m_out = mk(m_pc, 32'h0, 1'b0, 1'b1);
            skid.delete();
            if (m_busy && !resp) begin
                m_discard = 1;
                m_dest    = rpc & 32'hFFFF_FFFC;
            end else begin
                m_pc      = rpc & 32'hFFFF_FFFC;
                m_busy    = 1;
                m_discard = 0;
                m_boot    = 0;
            end
        end else begin
            if (adv) m_out = mk(m_pc, 32'h0, 1'b0, 1'b1);
            if (m_boot) begin
                m_boot = 0;
                m_busy = 1;
            end else if (m_busy && m_discard) begin
                if (resp) begin
                    m_pc      = m_dest;
                    m_discard = 0;
                end
            end else if (m_busy && ak) begin
                e = mk(m_pc, dat, 1'b0, 1'b0);
                if (adv) m_out = e;
                else begin skid.push_back(e); m_busy = 0; end
                m_pc = m_pc + 32'd4;
            end else if (m_busy && er) begin
                e = mk(m_pc, 32'h0, 1'b1, 1'b1);
                if (adv) m_out = e;
                else skid.push_back(e);
                m_busy = 0;
            end else if (skid.size() != 0 && adv) begin
                e = skid.pop_front();
                m_out = e;
                if (!e.flt) m_busy = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".id_pc"},   id_pc,                 m_out.pc);
        chk({tag, ".id_insn"}, id_insn,               m_out.insn);
        chk({tag, ".fault"},   32'(id_exc_ibus_fault), 32'(m_out.flt));
        chk({tag, ".bubble"},  32'(if_bubble),         32'(m_out.bub));
    endtask

    // One clock: drive after the falling edge, check bus, step at rising edge, check outputs.
    task automatic cycle(input logic st, input logic fl, input logic rd,
                         input logic [31:0] rpc, input logic ak, input logic er,
                         input logic [31:0] dat);
        id_stall = st; id_flush = fl; if_redirect = rd; if_redirect_pc = rpc;
        ibus_ack_i = ak; ibus_err_i = er; ibus_dat_i = dat;
        #1;
        chk("req", 32'(ibus_req_o), 32'(m_busy));
        chk("adr", ibus_adr_o, m_pc);
        @(posedge clk);
        model_step(st, fl, rd, rpc, ak, er, dat);
        #1;
        chk_outs("out");
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic ack(input logic st, input logic [31:0] dat);
        cycle(st, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, dat);
    endtask

    task automatic reset_mid();
        id_stall = 0; id_flush = 0; if_redirect = 0; if_redirect_pc = 0;
        ibus_ack_i = 0; ibus_err_i = 0; ibus_dat_i = 0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst.req", 32'(ibus_req_o), 32'd0);
        chk("rst.adr", ibus_adr_o, RPC);
        chk_outs("rst");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic st, fl, rd, ak, er;
        int   r;
        rst = 1'b1;
        id_stall = 0; id_flush = 0; if_redirect = 0; if_redirect_pc = 0;
        ibus_ack_i = 0; ibus_err_i = 0; ibus_dat_i = 0;
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("por.req", 32'(ibus_req_o), 32'd0);
        chk("por.adr", ibus_adr_o, RPC);
        chk("por.id_pc", id_pc, RPC);
        chk("por.id_insn", id_insn, 32'h0);
        chk("por.bubble", 32'(if_bubble), 32'd1);
        chk("por.fault", 32'(id_exc_ibus_fault), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        idle();
        chk("boot.req", 32'(ibus_req_o), 32'd1);
        chk("boot.adr", ibus_adr_o, 32'hE0000000);
        ack(1'b0, 32'h12345678);
        chk("zw.insn", id_insn, 32'h12345678);
        chk("zw.pc", id_pc, 32'hE0000000);
        chk("zw.bub", 32'(if_bubble), 32'd0);
        chk("zw.adr", ibus_adr_o, 32'hE0000004);

        ack(1'b1, 32'hAAAA0001);
        chk("stall.insn", id_insn, 32'h12345678);
        chk("stall.req", 32'(ibus_req_o), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();
        chk("drain.insn", id_insn, 32'hAAAA0001);
        chk("drain.pc", id_pc, 32'hE0000004);
        chk("drain.adr", ibus_adr_o, 32'hE0000008);

        cycle(1'b0, 1'b0, 1'b1, 32'h00001000, 1'b0, 1'b0, 32'h0);
        chk("abort.adr", ibus_adr_o, 32'hE0000008);
        idle();
        ack(1'b0, 32'hDEADBEEF);
        chk("abort.bub", 32'(if_bubble), 32'd1);
        chk("abort.insn", id_insn, 32'h0);
        chk("abort.next", ibus_adr_o, 32'h00001000);

        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("err.fault", 32'(id_exc_ibus_fault), 32'd1);
        chk("err.pc", id_pc, 32'h00001000);
        chk("err.insn", id_insn, 32'h0);
        for (int i = 0; i < 10; i++) idle();
        cycle(1'b0, 1'b0, 1'b1, 32'hE0000004, 1'b0, 1'b0, 32'h0);
        chk("halt.adr", ibus_adr_o, 32'hE0000004);
        chk("halt.fault", 32'(id_exc_ibus_fault), 32'd0);
        ack(1'b0, 32'h11111111);

        cycle(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h22222222);
        chk("wrap.adr", ibus_adr_o, 32'hFFFFFFFC);
        chk("wrap.bub", 32'(if_bubble), 32'd1);
        ack(1'b0, 32'hCAFEF00D);
        chk("wrap.pc", id_pc, 32'hFFFFFFFC);
        chk("wrap.next", ibus_adr_o, 32'h00000000);

        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h5A5A5A5A);
        chk("flush.insn", id_insn, 32'h5A5A5A5A);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        chk("serr.fault", 32'(id_exc_ibus_fault), 32'd0);
        idle();
        chk("serr.late", 32'(id_exc_ibus_fault), 32'd1);
        chk("serr.pc", id_pc, 32'h00000004);

        cycle(1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0, 32'h0);
        ack(1'b1, 32'h33333333);
        reset_mid();
        idle();
        ack(1'b0, 32'h44444444);
        chk("rrel.pc", id_pc, 32'hE0000000);
        chk("rrel.insn", id_insn, 32'h44444444);
        idle();
        reset_mid();
        idle();

        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                reset_mid();
            end else begin
                st = ($urandom_range(0, 9) < 3);
                fl = ($urandom_range(0, 9) == 0);
                rd = ($urandom_range(0, 19) == 0);
                ak = 1'b0;
                er = 1'b0;
                if (m_busy) begin
                    r  = int'($urandom_range(0, 99));
                    ak = (r < 55);
                    er = (r >= 55 && r < 59);
                end
                cycle(st, fl, rd, $urandom, ak, er, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
